// File: rtl/multi_button_step.sv
// Multi-channel push-button front end: synchronise, debounce, and emit Press/Release pulses.
// Define AUTOREPEAT_EN to add hold-to-repeat Press pulses while a button stays down.
module multi_button_step #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                BasysCLK,
    input  logic                Reset_n,
    input  logic [CHANNELS-1:0] Button,
    output logic [CHANNELS-1:0] Level,
    output logic [CHANNELS-1:0] Press,
    output logic [CHANNELS-1:0] Release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("multi_button_step: illegal parameter combination");
    end

`ifdef AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);
    localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_e;
`endif

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic          s1;
        logic          s2;
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          accept;

        // s2 has disagreed with the accepted level for DEBOUNCE_CYCLES samples in a row
        assign accept = (s2 != level_q) && (cnt == CNT_MAX);

`ifdef AUTOREPEAT_EN
        rep_state_e    state;
        logic [RW-1:0] rcnt;
`endif

        always_ff @(posedge BasysCLK) begin
            if (!Reset_n) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef AUTOREPEAT_EN
                state     <= IDLE;
                rcnt      <= '0;
`endif
            end else begin
                s1 <= Button[ch] ^ ACTIVE_LOW;
                s2 <= s1;
                // NOTE: pulses default low every edge and are only raised below, so each
                // is a registered one-cycle strobe; later non-blocking writes override this.
                press_q   <= 1'b0;
                release_q <= 1'b0;

                if (s2 == level_q) begin
                    cnt <= '0;
                end else if (accept) begin
                    cnt       <= '0;
                    level_q   <= s2;
                    press_q   <= s2;
                    release_q <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end

`ifdef AUTOREPEAT_EN
                case (state)
                    IDLE: begin
                        if (accept && s2) begin
                            state <= HOLD;
                            rcnt  <= '0;
                        end
                    end
                    HOLD: begin
                        // an accepted change while held is always a release, which wins
                        if (accept) begin
                            state <= IDLE;
                        end else if (rcnt == DELAY_MAX) begin
                            press_q <= 1'b1;
                            state   <= REPEAT;
                            rcnt    <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (accept) begin
                            state <= IDLE;
                        end else if (rcnt == PERIOD_MAX) begin
                            press_q <= 1'b1;
                            rcnt    <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end
                endcase
`endif
            end
        end

        assign Level[ch]   = level_q;
        assign Press[ch]   = press_q;
        assign Release[ch] = release_q;
    end

endmodule

// File: tb/tb_multi_button_step.sv
// Scoreboard bench for multi_button_step: an active-high and an active-low instance share one
// timestamp-based reference model; expected outputs are queued per edge and checked by a monitor.
module tb_multi_button_step;

    localparam int CHANNELS = 4;
    localparam int DEB      = 8;
    localparam int RD       = 20;
    localparam int RP       = 5;

    typedef struct packed {
        logic [CHANNELS-1:0] level;
        logic [CHANNELS-1:0] press;
        logic [CHANNELS-1:0] rel;
    } out_t;

    logic                BasysCLK = 1'b0;
    logic                rst_n    = 1'b0;
    logic [CHANNELS-1:0] pressed  = '0;
    logic [CHANNELS-1:0] pin_hi;
    logic [CHANNELS-1:0] pin_lo;
    logic [CHANNELS-1:0] level_hi, press_hi, rel_hi;
    logic [CHANNELS-1:0] level_lo, press_lo, rel_lo;

    assign pin_hi = pressed;
    assign pin_lo = ~pressed;

    always #5 BasysCLK = ~BasysCLK;

    multi_button_step #(
        .CHANNELS(CHANNELS), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .BasysCLK(BasysCLK), .Reset_n(rst_n), .Button(pin_hi),
        .Level(level_hi), .Press(press_hi), .Release(rel_hi)
    );

    multi_button_step #(
        .CHANNELS(CHANNELS), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_al (
        .BasysCLK(BasysCLK), .Reset_n(rst_n), .Button(pin_lo),
        .Level(level_lo), .Press(press_lo), .Release(rel_lo)
    );

    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    out_t exp_q[$];

    // Reference model: pressed state seen two edges late, a streak of disagreeing samples,
    // and the edge index of the last accepted press for repeat timing.
    logic [CHANNELS-1:0] m_d1 = '0;
    logic [CHANNELS-1:0] m_d2 = '0;
    logic [CHANNELS-1:0] m_lvl = '0;
    int                  m_streak[CHANNELS];
    int                  m_pedge[CHANNELS];
    int                  edge_n = 0;

    task automatic check(input string name, input logic [CHANNELS-1:0] act,
                         input logic [CHANNELS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    function automatic void model_edge(input logic [CHANNELS-1:0] p, input logic r);
        out_t e;
        int   dt;
        e = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!r) begin
                m_d1[c] = 1'b0;
                m_d2[c] = 1'b0;
                m_lvl[c] = 1'b0;
                m_streak[c] = 0;
            end else begin
                if (m_d2[c] != m_lvl[c]) begin
                    m_streak[c]++;
                    if (m_streak[c] == DEB) begin
                        m_lvl[c] = m_d2[c];
                        m_streak[c] = 0;
                        if (m_lvl[c]) begin
                            e.press[c] = 1'b1;
                            m_pedge[c] = edge_n;
                        end else begin
                            e.rel[c] = 1'b1;
                        end
                    end
                end else begin
                    m_streak[c] = 0;
                end
`ifdef AUTOREPEAT_EN
                if (m_lvl[c] && !e.press[c]) begin
                    dt = edge_n - m_pedge[c];
                    if (dt == RD || (dt > RD && (dt - RD) % RP == 0))
                        e.press[c] = 1'b1;
                end
`endif
                m_d2[c] = m_d1[c];
                m_d1[c] = p[c];
            end
            e.level[c] = m_lvl[c];
        end
        dt = 0;
        edge_n++;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input logic [CHANNELS-1:0] p, input logic r);
        @(negedge BasysCLK);
        pressed = p;
        rst_n   = r;
        started = 1'b1;
        model_edge(p, r);
    endtask

    // Monitor: one expected entry is consumed per rising edge once stimulus has begun.
    always @(posedge BasysCLK) begin
        out_t e;
        #1;
        if (started) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty at %0t: actual=0 entries required>=1", $time);
            end else begin
                e = exp_q.pop_front();
                check("level_hi",   level_hi, e.level);
                check("press_hi",   press_hi, e.press);
                check("release_hi", rel_hi,   e.rel);
                check("level_lo",   level_lo, e.level);
                check("press_lo",   press_lo, e.press);
                check("release_lo", rel_lo,   e.rel);
            end
        end
    end

    initial begin
        logic [CHANNELS-1:0] v;
        for (int c = 0; c < CHANNELS; c++) begin
            m_streak[c] = 0;
            m_pedge[c]  = 0;
        end

        // reset while all buttons held, then fresh presses after debounce
        repeat (3)  tick(4'hF, 1'b0);
        repeat (14) tick(4'hF, 1'b1);
        repeat (14) tick(4'h0, 1'b1);

        // clean press on ch0
        repeat (40) tick(4'h1, 1'b1);
        repeat (14) tick(4'h0, 1'b1);

        // ch1 bounces every 3 cycles, then settles pressed
        for (int i = 0; i < 30; i++) begin
            v = '0;
            v[1] = ((i / 3) % 2 == 0);
            tick(v, 1'b1);
        end
        repeat (20) tick(4'h2, 1'b1);
        repeat (14) tick(4'h0, 1'b1);

        // ch2 press then release
        repeat (20) tick(4'h4, 1'b1);
        repeat (14) tick(4'h0, 1'b1);

        // ch3 held 60 raw cycles: debounced fall lands on a repeat expiry
        repeat (60) tick(4'h8, 1'b1);
        repeat (14) tick(4'h0, 1'b1);

        // reset in the middle of a repeat run, button stays held
        repeat (35) tick(4'h8, 1'b1);
        repeat (2)  tick(4'h8, 1'b0);
        repeat (40) tick(4'h8, 1'b1);
        repeat (14) tick(4'h0, 1'b1);

        // random bouncing on all channels with occasional resets
        v = '0;
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < CHANNELS; c++)
                if ($urandom_range(0, 9) == 0) v[c] = ~v[c];
            tick(v, ($urandom_range(0, 149) != 0));
        end
        repeat (14) tick(4'h0, 1'b1);

        @(posedge BasysCLK);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d entries required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_button_step.md
# multi_button_step

Parametrised multi-channel push-button front end for the Basys3 board: synchronises CHANNELS raw buttons into the BasysCLK domain, debounces each one with a stable-time counter, and emits single-cycle Press/Release pulses for CPU single-stepping and user input. Optional hold-to-repeat generates periodic Press pulses while a button stays down, for free-running stepping. Sits between the board pins and the CPU clock-enable / input logic.

## Interface
- CHANNELS, 4, number of independent buttons (≥1)
- DEBOUNCE_CYCLES, 2000000, consecutive stable samples required to accept a level change (20 ms at 100 MHz; ≥2)
- ACTIVE_LOW, 0, 1 = raw button pressed when 0 (inverted before synchroniser)
- REPEAT_DELAY, 50000000, cycles from accepted press to first repeat pulse (≥2; used only with AUTOREPEAT_EN)
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (≥2; used only with AUTOREPEAT_EN)
- BasysCLK  input  1  system clock; all logic on rising edge
- Reset_n  input  1  reset, synchronous, active-low
- Button  input  CHANNELS  raw asynchronous button pins
- Level  output  CHANNELS  debounced pressed state, 1 = pressed
- Press  output  CHANNELS  one-cycle pulse per accepted press (and per repeat)
- Release  output  CHANNELS  one-cycle pulse per accepted release

## Operation
- Per channel, fully independent; no shared state.
- Input conditioning: b = Button ^ ACTIVE_LOW; two-flop synchroniser s1 <= b, s2 <= s1.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES): if s2 == Level, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, Level <= s2, cnt <= 0; else cnt <= cnt+1. Any single sample equal to Level restarts the count (glitch rejection).
- Press asserted on the edge Level goes 0→1; Release on the edge Level goes 1→0; both registered, high exactly one cycle.
- Press and Release never both high on one channel in the same cycle.
- All outputs and internal state reset to 0 / IDLE when Reset_n = 0 at a rising edge; reset mid-debounce or mid-repeat discards progress, no pulse issued on the reset edge or the first edge after.
- After reset, a button already held is accepted as a fresh press (Press pulse) after the normal debounce latency.

## Timing
- Raw level stable ahead of edge 0: s2 changes at edge 1; Level and Press/Release update at edge DEBOUNCE_CYCLES+1.
- A bounce shorter than DEBOUNCE_CYCLES cycles at s2 produces no output change.
- Pulse outputs are flop outputs; no combinational path from Button to any output.

## Configuration
- Macro AUTOREPEAT_EN.
- Defined: per-channel FSM IDLE → HOLD → REPEAT with repeat counter rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)).
  - IDLE: on accepted press at edge P → HOLD, rcnt <= 0 (normal Press at P).
  - HOLD: rcnt increments; at rcnt == REPEAT_DELAY-1 → Press pulse, REPEAT, rcnt <= 0; pulse at edge P+REPEAT_DELAY.
  - REPEAT: at rcnt == REPEAT_PERIOD-1 → Press pulse, rcnt <= 0; pulses at P+REPEAT_DELAY+k·REPEAT_PERIOD, k≥1.
  - Accepted release in HOLD/REPEAT → IDLE on that edge, Release pulse; a repeat expiry on the same edge is suppressed (release wins).
- Undefined: no FSM/rcnt logic; exactly one Press per accepted press; REPEAT_* parameters ignored.

## Test plan
Bench parameters: CHANNELS=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, ACTIVE_LOW=0 unless stated.
- Reset: hold Reset_n=0 for 3 cycles with Button=4'hF -> Level/Press/Release all 0 during reset; Press=4'hF exactly once, 9 edges after release of reset sampling.
- Clean press ch0: Button[0] 0→1 before edge 0, held 40 cycles -> Level[0]=1 and Press[0] one cycle at edge 9; no other channel changes.
- Bounce ch1: Button[1] toggles every 3 cycles for 30 cycles then settles 1 -> no Press during bouncing; single Press[1] 9 edges after the last toggle.
- Release ch2 with ACTIVE_LOW=1: Button[2] driven 0 then 1 -> Press then Release[2] each exactly one cycle, Level[2] tracks inverted pin.
- AUTOREPEAT_EN defined, ch3 held 60 cycles from press edge P -> Press[3] at P, P+20, P+25, P+30, …; release timed so debounced fall coincides with a repeat expiry -> Release only, no Press that edge.
- Reset mid-repeat: assert Reset_n=0 during REPEAT -> outputs 0 next edge, FSM IDLE; after release, held button yields normal Press after 9 edges and restarts REPEAT_DELAY.
